// File: rtl/player_shot_ctrl.sv
// Player bullet scheduler: fires on shoot-button edges into a pool of slots,
// moves live bullets upward once per frame tick, retires them on hit or top exit.
module player_shot_ctrl #(
  parameter int unsigned num_slots_p = 2,
  parameter int unsigned cooldown_p  = 16,
  parameter int unsigned step_p      = 4,
  parameter int unsigned spawn_y_p   = 440,
  parameter int unsigned top_y_p     = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      shoot_i,
  input  logic                      tick_i,
  input  logic                      enable_i,
  input  logic                      clear_i,
  input  logic [9:0]                pos_left_i,
  input  logic [9:0]                pos_right_i,
  input  logic [num_slots_p-1:0]    hit_slot_i,
  output logic [num_slots_p-1:0]    active_o,
  output logic [10*num_slots_p-1:0] bullet_x_o,
  output logic [10*num_slots_p-1:0] bullet_y_o,
  output logic                      fire_o,
  output logic                      ready_o,
  output logic [7:0]                cooldown_o
);

  localparam int unsigned coord_w = 10;
  localparam int unsigned cnt_w   = 8;

  localparam logic [coord_w-1:0] spawn_y  = coord_w'(spawn_y_p);
  localparam logic [coord_w-1:0] step_y   = coord_w'(step_p);
  localparam logic [coord_w-1:0] retire_y = coord_w'(top_y_p + step_p);
  localparam logic [cnt_w-1:0]   cd_load  = cnt_w'(cooldown_p);

  typedef enum logic {
    SLOT_IDLE   = 1'b0,
    SLOT_FLYING = 1'b1
  } slot_state_t;

  slot_state_t        state_q [num_slots_p];
  slot_state_t        state_d [num_slots_p];
  logic [coord_w-1:0] x_q     [num_slots_p];
  logic [coord_w-1:0] x_d     [num_slots_p];
  logic [coord_w-1:0] y_q     [num_slots_p];
  logic [coord_w-1:0] y_d     [num_slots_p];
  logic [cnt_w-1:0]   cooldown_q, cooldown_d;
  logic               shoot_prev_q;
  logic               fire_q, fire_d;

  logic                   press, accept, move, found;
  logic [num_slots_p-1:0] alloc_oh;
  logic [coord_w:0]       pos_sum;
  logic [coord_w-1:0]     spawn_x;

  // Registered state; shoot history tracks the button even while frozen
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(num_slots_p); i++) begin
        state_q[i] <= SLOT_IDLE;
        x_q[i]     <= '0;
        y_q[i]     <= '0;
      end
      cooldown_q   <= '0;
      shoot_prev_q <= 1'b0;
      fire_q       <= 1'b0;
    end else begin
      for (int i = 0; i < int'(num_slots_p); i++) begin
        state_q[i] <= state_d[i];
        x_q[i]     <= x_d[i];
        y_q[i]     <= y_d[i];
      end
      cooldown_q   <= cooldown_d;
      shoot_prev_q <= shoot_i;
      fire_q       <= fire_d;
    end
  end

  // Next-state: clear > hit > load > move, per slot
  always_comb begin
    press    = shoot_i & ~shoot_prev_q;
    move     = tick_i & enable_i;
    found    = 1'b0;
    alloc_oh = '0;
    pos_sum  = (coord_w+1)'(pos_left_i) + (coord_w+1)'(pos_right_i);
    spawn_x  = pos_sum[coord_w:1];

    // Lowest free slot, judged from registered state only
    for (int i = 0; i < int'(num_slots_p); i++) begin
      if (!found && state_q[i] == SLOT_IDLE) begin
        alloc_oh[i] = 1'b1;
        found       = 1'b1;
      end
    end

    accept  = press & enable_i & ~clear_i & (cooldown_q == '0) & found;
    ready_o = (cooldown_q == '0) & found & enable_i;
    fire_d  = accept;

    for (int i = 0; i < int'(num_slots_p); i++) begin
      state_d[i] = state_q[i];
      x_d[i]     = x_q[i];
      y_d[i]     = y_q[i];
      if (clear_i || (state_q[i] == SLOT_FLYING && hit_slot_i[i])) begin
        state_d[i] = SLOT_IDLE;
        x_d[i]     = '0;
        y_d[i]     = '0;
      end else if (accept && alloc_oh[i]) begin
        state_d[i] = SLOT_FLYING;
        x_d[i]     = spawn_x;
        y_d[i]     = spawn_y;
      end else if (state_q[i] == SLOT_FLYING && move) begin
        if (y_q[i] < retire_y) begin
          state_d[i] = SLOT_IDLE;
          x_d[i]     = '0;
          y_d[i]     = '0;
        end else begin
          y_d[i] = y_q[i] - step_y;
        end
      end
    end

    cooldown_d = cooldown_q;
    if (clear_i) begin
      cooldown_d = '0;
    end else if (accept) begin
      cooldown_d = cd_load;
    end else if (move && cooldown_q != '0) begin
      cooldown_d = cooldown_q - cnt_w'(1);
    end
  end

  // Flatten per-slot registers onto the packed output buses
  always_comb begin
    active_o   = '0;
    bullet_x_o = '0;
    bullet_y_o = '0;
    for (int i = 0; i < int'(num_slots_p); i++) begin
      active_o[i]                  = (state_q[i] == SLOT_FLYING);
      bullet_x_o[10*i +: coord_w]  = x_q[i];
      bullet_y_o[10*i +: coord_w]  = y_q[i];
    end
  end

  assign fire_o     = fire_q;
  assign cooldown_o = cooldown_q;

endmodule
